aoi22_arc_driver: RTL and testbench



---
 rtl/aoi22_arc_driver.sv | 185 ++++++++++++++++++
 tb/tb_aoi22_arc_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aoi22_arc_driver.sv
`timescale 1ns/1ps
`default_nettype none
// aoi22_arc_driver: walks the 12 state-dependent arcs of an AOI22/OAI22 cell and checks Y (rev 1.0).
// Optional: define AOI22_ARC_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module aoi22_arc_driver #(
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 8,
    parameter int OAI_MODE = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             Y_IN,
    output logic             A0,
    output logic             A1,
    output logic             B0,
    output logic             B1,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [3:0]       ARC_IDX,
    output logic [5:0]       FIRST_FAIL
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 2);
    localparam logic [3:0]       LAST_ARC    = 4'd11;
    localparam logic             IS_OAI      = (OAI_MODE != 0);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state, state_nxt;
    logic       y_meta, y_sync;
    logic [1:0] phase;
    logic [7:0] settle_cnt;
    logic [1:0] pin, side;
    logic       pin_val, partner;
    logic [1:0] other;
    logic [3:0] vec;
    logic       exp_y, mismatch, last_phase, stop_now;

    // arc = pin*3 + side condition
    always_comb begin
        pin  = 2'd0;
        side = 2'd0;
        if (ARC_IDX >= 4'd9) begin
            pin  = 2'd3;
            side = 2'(ARC_IDX - 4'd9);
        end else if (ARC_IDX >= 4'd6) begin
            pin  = 2'd2;
            side = 2'(ARC_IDX - 4'd6);
        end else if (ARC_IDX >= 4'd3) begin
            pin  = 2'd1;
            side = 2'(ARC_IDX - 4'd3);
        end else begin
            side = ARC_IDX[1:0];
        end
    end

    // OAI side conditions are the bitwise complement of the AOI ones
    always_comb begin
        pin_val = (phase == 2'd1);
        partner = ~IS_OAI;
        case (side)
            2'd0:    other = 2'b10;
            2'd1:    other = 2'b01;
            default: other = 2'b00;
        endcase
        other = other ^ {2{IS_OAI}};
        case (pin)
            2'd0:    vec = {pin_val, partner, other};
            2'd1:    vec = {partner, pin_val, other};
            2'd2:    vec = {other, pin_val, partner};
            default: vec = {other, partner, pin_val};
        endcase
    end

    always_comb begin
        exp_y      = IS_OAI ? ~((A0 | A1) & (B0 | B1)) : ~((A0 & A1) | (B0 & B1));
        mismatch   = (y_sync != exp_y);
        last_phase = (phase == 2'd2) && (ARC_IDX == LAST_ARC);
`ifdef AOI22_ARC_STOP_ON_FAIL_EN
        stop_now   = mismatch;
`else
        stop_now   = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (START && !ABORT) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = (stop_now || last_phase) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && ABORT) state_nxt = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            y_meta           <= 1'b0;
            y_sync           <= 1'b0;
            {A0, A1, B0, B1} <= 4'b0;
            BUSY             <= 1'b0;
            DONE             <= 1'b0;
            PASS             <= 1'b0;
            ERR_CNT          <= '0;
            ARC_IDX          <= 4'd0;
            FIRST_FAIL       <= 6'd0;
            phase            <= 2'd0;
            settle_cnt       <= 8'd0;
        end else begin
            y_meta <= Y_IN;
            y_sync <= y_meta;
            if (state == ST_IDLE) begin
                if (START && !ABORT) begin
                    ERR_CNT    <= '0;
                    FIRST_FAIL <= 6'd0;
                    DONE       <= 1'b0;
                    PASS       <= 1'b0;
                    BUSY       <= 1'b1;
                    ARC_IDX    <= 4'd0;
                    phase      <= 2'd0;
                end
            end else if (ABORT) begin
                {A0, A1, B0, B1} <= 4'b0;
                BUSY             <= 1'b0;
                DONE             <= 1'b0;
                PASS             <= 1'b0;
            end else begin
                case (state)
                    ST_DRIVE: begin
                        {A0, A1, B0, B1} <= vec;
                        settle_cnt       <= 8'd0;
                    end
                    ST_SETTLE: settle_cnt <= settle_cnt + 8'd1;
                    ST_SAMPLE: begin
                        if (mismatch) begin
                            if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + CNT_ONE;
                            if (!FIRST_FAIL[5]) FIRST_FAIL <= {1'b1, ARC_IDX, pin_val};
                        end
                        if (stop_now) begin
                            // failing vector stays on the pins through the DONE state
                            BUSY <= 1'b0;
                            DONE <= 1'b1;
                            PASS <= 1'b0;
                        end else if (phase == 2'd2) begin
                            phase <= 2'd0;
                            if (ARC_IDX != LAST_ARC) ARC_IDX <= ARC_IDX + 4'd1;
                            else {A0, A1, B0, B1} <= 4'b0;
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end
                    ST_DONE: begin
                        {A0, A1, B0, B1} <= 4'b0;
                        BUSY             <= 1'b0;
                        DONE             <= 1'b1;
                        PASS             <= (ERR_CNT == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aoi22_arc_driver.sv
`timescale 1ns/1ps
`default_nettype none
// tb_aoi22_arc_driver: random-fault sweeps on an AOI22 and an OAI22 driver, scoreboard-checked.
module tb_aoi22_arc_driver;

    localparam int S      = 4;
    localparam int PH     = S + 1;
    localparam int LAT    = 36 * PH + 1;
    localparam int K_FULL = 0;
    localparam int K_ABRT = 1;
    localparam int K_RST  = 2;

    logic clk = 1'b0, rn = 1'b0, start = 1'b0, abort = 1'b0;
    logic a0, a1, b0, b1, busy, done, pass;
    logic [7:0] err;
    logic [3:0] arc;
    logic [5:0] ff;
    logic oa0, oa1, ob0, ob1, obusy, odone, opass;
    logic [3:0] oerr;
    logic [3:0] oarc;
    logic [5:0] off;
    logic y_a, y_o;
    int mode = 0;
    logic [15:0] fmask = 16'h0;
    int checks = 0, failures = 0;

    typedef struct {
        int         kind;
        int         m;
        int         arc;
        int         err_a;
        logic [5:0] ff_a;
        int         err_o;
        logic [5:0] ff_o;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Drive vector {A0,A1,B0,B1} for an arc/phase, straight from the sensitization rules
    function automatic logic [3:0] spec_vec(input bit oai, input int a, input int ph);
        logic d [0:3];
        int pin, k, g;
        logic [1:0] pair;
        pin = a / 3;
        k   = a % 3;
        if (!oai) pair = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
        else      pair = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b11;
        d[pin]     = (ph == 1);
        d[pin ^ 1] = !oai;
        g          = (pin < 2) ? 2 : 0;
        d[g]       = pair[1];
        d[g + 1]   = pair[0];
        return {d[0], d[1], d[2], d[3]};
    endfunction

    // Cell under test: ideal, stuck-at-1, stuck-at-0, or ideal with per-vector inversions
    function automatic logic cell_y(input bit oai, input int md, input logic [15:0] fm, input logic [3:0] v);
        logic ideal;
        ideal = oai ? ~((v[3] | v[2]) & (v[1] | v[0])) : ~((v[3] & v[2]) | (v[1] & v[0]));
        case (md)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ideal ^ fm[v];
            default: return ideal;
        endcase
    endfunction

    function automatic void model(input bit oai, input int md, input logic [15:0] fm, input int nph,
                                  input int satmax, output int e, output logic [5:0] f);
        int a, ph;
        e = 0;
        f = 6'd0;
        for (int i = 0; i < nph; i++) begin
            a  = i / 3;
            ph = i % 3;
            if (cell_y(oai, md, fm, spec_vec(oai, a, ph)) != (ph != 1)) begin
                if (e < satmax) e++;
                if (!f[5]) f = {1'b1, 4'(a), ph == 1};
            end
        end
    endfunction

    assign y_a = cell_y(1'b0, mode, fmask, {a0, a1, b0, b1});
    assign y_o = cell_y(1'b1, mode, 16'h0, {oa0, oa1, ob0, ob1});

    aoi22_arc_driver #(.SETTLE(S), .CNT_W(8), .OAI_MODE(0)) dut_aoi (
        .CLK(clk), .RN(rn), .START(start), .ABORT(abort), .Y_IN(y_a),
        .A0(a0), .A1(a1), .B0(b0), .B1(b1), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_CNT(err), .ARC_IDX(arc), .FIRST_FAIL(ff)
    );

    aoi22_arc_driver #(.SETTLE(S), .CNT_W(4), .OAI_MODE(1)) dut_oai (
        .CLK(clk), .RN(rn), .START(start), .ABORT(abort), .Y_IN(y_o),
        .A0(oa0), .A1(oa1), .B0(ob0), .B1(ob1), .BUSY(obusy), .DONE(odone), .PASS(opass),
        .ERR_CNT(oerr), .ARC_IDX(oarc), .FIRST_FAIL(off)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t cur;
        bit   tracking;
        int   n;
        tracking = 1'b0;
        n        = 0;
        forever begin
            @(negedge clk);
            if (tracking) n++;
            else if (busy) begin
                chk("sweep_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    tracking = 1'b1;
                    n        = 0;
                end
            end
            if (tracking) begin
                if (n % PH == 2 && n / PH < 36 && (cur.kind == K_FULL || n < cur.m)) begin
                    chk("aoi_vec", 32'({a0, a1, b0, b1}), 32'(spec_vec(1'b0, (n / PH) / 3, (n / PH) % 3)));
                    chk("oai_vec", 32'({oa0, oa1, ob0, ob1}), 32'(spec_vec(1'b1, (n / PH) / 3, (n / PH) % 3)));
                end
                if (cur.kind == K_FULL) begin
                    if (n == LAT - 1) chk("done_not_early", 32'({busy, done}), 32'b10);
                    if (n == LAT) begin
                        chk("done_rise", 32'({busy, done}), 32'b01);
                        chk("pass", 32'(pass), 32'(cur.err_a == 0));
                        chk("err_cnt", 32'(err), 32'(cur.err_a));
                        chk("first_fail", 32'(ff), 32'(cur.ff_a));
                        chk("drive_idle", 32'({a0, a1, b0, b1}), 32'd0);
                        chk("arc_final", 32'(arc), 32'd11);
                        chk("oai_done", 32'({obusy, odone}), 32'b01);
                        chk("oai_pass", 32'(opass), 32'(cur.err_o == 0));
                        chk("oai_err_cnt", 32'(oerr), 32'(cur.err_o));
                        chk("oai_first_fail", 32'(off), 32'(cur.ff_o));
                        tracking = 1'b0;
                    end
                end else if (cur.kind == K_ABRT) begin
                    if (n == cur.m - 1) chk("abort_arc", 32'(arc), 32'(cur.arc));
                    if (n == cur.m) begin
                        chk("abort_state", 32'({busy, done, pass, a0, a1, b0, b1}), 32'd0);
                        chk("abort_err_cnt", 32'(err), 32'(cur.err_a));
                        chk("abort_first_fail", 32'(ff), 32'(cur.ff_a));
                        chk("oai_abort_state", 32'({obusy, odone, opass, oa0, oa1, ob0, ob1}), 32'd0);
                        chk("oai_abort_err_cnt", 32'(oerr), 32'(cur.err_o));
                        tracking = 1'b0;
                    end
                end else if (n == cur.m) begin
                    tracking = 1'b0;
                end
            end
        end
    end

    task automatic run_sweep(input int kind, input int m);
        exp_t e;
        int   nph, rs;
        bit   finished;
        nph    = (kind == K_FULL) ? 36 : (m - 1) / PH;
        e.kind = kind;
        e.m    = m;
        e.arc  = ((m - 1) / PH) / 3;
        model(1'b0, mode, fmask, nph, 255, e.err_a, e.ff_a);
        model(1'b1, (mode == 3) ? 0 : mode, 16'h0, nph, 15, e.err_o, e.ff_o);
        exp_q.push_back(e);
        finished = 1'b0;
        rs       = $urandom_range(3, 150);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (kind == K_FULL) start = (c == rs);
            if (kind == K_ABRT) abort = (c == m - 1);
            if (kind == K_RST && c == m) begin
                #2 rn = 1'b0;
                #1 chk("async_reset", 32'({a0, a1, b0, b1, busy, done, pass, err, arc, ff}), 32'd0);
                chk("oai_async_reset", 32'({oa0, oa1, ob0, ob1, obusy, odone, opass, oerr, oarc, off}), 32'd0);
                @(negedge clk);
                rn       = 1'b1;
                finished = 1'b1;
                break;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk("sweep_finished", 32'(finished), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({a0, a1, b0, b1, busy, done, pass, err, arc, ff}), 32'd0);
        rn = 1'b1;
        @(negedge clk);

        mode = 0;
        run_sweep(K_FULL, 0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", 32'({busy, done, pass}), 32'b011);

        mode = 1;
        run_sweep(K_FULL, 0);
        mode = 2;
        run_sweep(K_FULL, 0);
        mode = 0;
        run_sweep(K_ABRT, 15 * PH + 3);

        for (int i = 0; i < 5; i++) begin
            mode  = $urandom_range(0, 3);
            fmask = 16'($urandom);
            if ($urandom_range(0, 2) == 0) run_sweep(K_ABRT, $urandom_range(10, 170));
            else                           run_sweep(K_FULL, 0);
        end

        mode = 3;
        fmask = 16'($urandom);
        run_sweep(K_FULL, 0);
        mode = 0;
        run_sweep(K_RST, 60);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
